// File: rtl/spi_slave_port.sv
// SPI slave endpoint (mode: MOSI launched on SCLK rise, sampled on fall), LSB first, oversampled in clk.
// Optional define SPI_SLAVE_FRAME_ERROR_EN enables the frameError abort pulse.
module spi_slave_port #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCLK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [DATA_WIDTH-1:0] slaveDataToSend,
  input  logic                  load,
  output logic [DATA_WIDTH-1:0] slaveDataReceived,
  output logic                  rxValid,
  output logic                  busy,
  output logic                  frameError,
  output logic [1:0]            dbg_state
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t state, state_d;

  // Index 0 is the pin side; [SYNC_STAGES-1] is the synchronised value and
  // [SYNC_STAGES] its one-cycle-old copy used for edge detection.
  logic [SYNC_STAGES:0]   sclk_s, cs_s;
  logic [SYNC_STAGES-1:0] mosi_s;

  logic [DATA_WIDTH-1:0] holding, hold_d;
  logic [DATA_WIDTH-1:0] tx_shift, tx_d;
  logic [DATA_WIDTH-1:0] rx_shift, rx_d;
  logic [DATA_WIDTH-1:0] rx_data, rx_data_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic                  miso_q, miso_d;
  logic                  rx_valid_q, rx_valid_d;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_bit;

  assign sclk_rise = sclk_s[SYNC_STAGES-1] & ~sclk_s[SYNC_STAGES];
  assign sclk_fall = ~sclk_s[SYNC_STAGES-1] & sclk_s[SYNC_STAGES];
  assign cs_rise   = cs_s[SYNC_STAGES-1] & ~cs_s[SYNC_STAGES];
  assign cs_fall   = ~cs_s[SYNC_STAGES-1] & cs_s[SYNC_STAGES];
  assign mosi_bit  = mosi_s[SYNC_STAGES-1];

  // A load in the same cycle as a (re)load of the tx shifter wins over the old holding value.
  assign hold_d = load ? slaveDataToSend : holding;

`ifdef SPI_SLAVE_FRAME_ERROR_EN
  logic frame_err_q, frame_err_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s     <= '0;
      cs_s       <= '1;
      mosi_s     <= '0;
      state      <= IDLE;
      holding    <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      rx_data    <= '0;
      cnt        <= '0;
      miso_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      sclk_s     <= {sclk_s[SYNC_STAGES-1:0], SCLK};
      cs_s       <= {cs_s[SYNC_STAGES-1:0], CS};
      mosi_s     <= {mosi_s[SYNC_STAGES-2:0], MOSI};
      state      <= state_d;
      holding    <= hold_d;
      tx_shift   <= tx_d;
      rx_shift   <= rx_d;
      rx_data    <= rx_data_d;
      cnt        <= cnt_d;
      miso_q     <= miso_d;
      rx_valid_q <= rx_valid_d;
    end
  end

`ifdef SPI_SLAVE_FRAME_ERROR_EN
  always_ff @(posedge clk) begin
    if (reset) frame_err_q <= 1'b0;
    else       frame_err_q <= frame_err_d;
  end
`endif

  always_comb begin
    state_d    = state;
    tx_d       = tx_shift;
    rx_d       = rx_shift;
    rx_data_d  = rx_data;
    cnt_d      = cnt;
    miso_d     = miso_q;
    rx_valid_d = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERROR_EN
    frame_err_d = 1'b0;
`endif
    case (state)
      IDLE: begin
        miso_d = 1'b0;
        cnt_d  = '0;
        if (cs_fall) state_d = LOAD;
      end
      LOAD: begin
        tx_d    = hold_d;
        cnt_d   = '0;
        miso_d  = hold_d[0];
        state_d = SHIFT;
        if (cs_rise) begin
          miso_d  = 1'b0;
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // CS release takes priority; a coincident SCLK fall is dropped.
        if (cs_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
          rx_d    = '0;
          miso_d  = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERROR_EN
          frame_err_d = (cnt != '0);
`endif
        end else if (sclk_fall) begin
          rx_d = {mosi_bit, rx_shift[DATA_WIDTH-1:1]};
          tx_d = tx_shift >> 1;
          if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
            rx_data_d  = rx_d;
            rx_valid_d = 1'b1;
            cnt_d      = '0;
            tx_d       = hold_d;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end else if (sclk_rise) begin
          miso_d = tx_shift[0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign MISO              = miso_q;
  assign slaveDataReceived = rx_data;
  assign rxValid           = rx_valid_q;
  assign busy              = (state != IDLE);
  assign dbg_state         = state;

`ifdef SPI_SLAVE_FRAME_ERROR_EN
  assign frameError = frame_err_q;
`else
  assign frameError = 1'b0;
`endif

endmodule
